// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
//   Bundles every bus signal of wb_port_arbiter: the pipeline WB request,
//   the long-unit issue/result channels, the decode hazard query, the
//   register-file write port, the perf counters and the FSM debug state.
//
//   modport slave  : the arbiter's view (consumes requests, drives the port)
//   modport master : the environment's view (pipeline, long unit, decode)
//
//   lu_wb valid/ready: a result transfers in any cycle where lu_wb_valid and
//   lu_wb_ready are both high; ready never depends on valid, and a producer
//   that sees ready low keeps its result and tries again next cycle.
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;

    logic        lu_issue_valid;
    logic [4:0]  lu_issue_rd;

    logic        lu_wb_valid;
    logic        lu_wb_ready;
    logic [4:0]  lu_wb_rd;
    logic [31:0] lu_wb_data;

    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_rs1_used;
    logic        dec_rs2_used;
    logic        dec_regwen;

    logic        stall_decode;
    logic        stall_pipe;

    logic        wb_regwen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [31:0] perf_conflicts;
    logic [31:0] perf_forced;

    logic [1:0]  dbg_state;

    modport slave (
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        input  lu_issue_valid, lu_issue_rd,
        input  lu_wb_valid, lu_wb_rd, lu_wb_data,
        output lu_wb_ready,
        input  dec_rs1, dec_rs2, dec_rd, dec_rs1_used, dec_rs2_used, dec_regwen,
        output stall_decode, stall_pipe,
        output wb_regwen, wb_rd, wb_data,
        output perf_conflicts, perf_forced,
        output dbg_state
    );

    modport master (
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        output lu_issue_valid, lu_issue_rd,
        output lu_wb_valid, lu_wb_rd, lu_wb_data,
        input  lu_wb_ready,
        output dec_rs1, dec_rs2, dec_rd, dec_rs1_used, dec_rs2_used, dec_regwen,
        input  stall_decode, stall_pipe,
        input  wb_regwen, wb_rd, wb_data,
        input  perf_conflicts, perf_forced,
        input  dbg_state
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order WB
//   stage and an out-of-band long-latency unit. Long-unit results that lose
//   the port are buffered in a DEPTH-entry FIFO; a per-register scoreboard
//   tracks destinations of outstanding long-unit ops and stalls decode on
//   RAW/WAW hazards. A FIFO head denied STARVE_LIMIT cycles in a row gets a
//   one-cycle forced write while the whole pipeline is frozen.
//
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_port_arbiter_if.slave (request, result, hazard and write
//              port signals, perf counters, dbg_state = FSM state)
//
// Parameters
//   DEPTH        : FIFO entries (power of two, >= 2)
//   STARVE_LIMIT : denied cycles tolerated before a forced head write
//
// Build option
//   WB_ARB_PERF_EN : when defined, perf_conflicts / perf_forced are live
//                    32-bit wrapping counters; otherwise both read 0.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(STARVE_LIMIT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t          state;
    logic [WW-1:0]   wait_cnt;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [4:0]      fifo_rd   [DEPTH];
    logic [31:0]     fifo_data [DEPTH];
    logic [31:0]     sb;

    logic            fifo_empty;
    logic            lu_ready;
    logic            sel_pipe;
    logic            deq;
    logic            direct;
    logic            enq;
    logic            port_valid;
    logic [4:0]      port_rd;
    logic [31:0]     port_data;
    logic [CW-1:0]   count_next;
    logic [31:0]     sb_next;

    assign fifo_empty = (count == '0);
    assign lu_ready   = (count < CW'(DEPTH));

    // Port source selection. FORCE overrides the pipeline; direct
    // pass-through only when nothing else wants the port.
    always_comb begin
        sel_pipe = 1'b0;
        deq      = 1'b0;
        direct   = 1'b0;
        if (state == S_FORCE)        deq      = 1'b1;
        else if (bus.pipe_wb_valid)  sel_pipe = 1'b1;
        else if (!fifo_empty)        deq      = 1'b1;
        else if (bus.lu_wb_valid)    direct   = 1'b1;
    end

    always_comb begin
        port_rd   = '0;
        port_data = '0;
        if (sel_pipe) begin
            port_rd   = bus.pipe_wb_rd;
            port_data = bus.pipe_wb_data;
        end else if (deq) begin
            port_rd   = fifo_rd[rd_ptr];
            port_data = fifo_data[rd_ptr];
        end else if (direct) begin
            port_rd   = bus.lu_wb_rd;
            port_data = bus.lu_wb_data;
        end
    end

    assign port_valid = sel_pipe | deq | direct;
    assign enq        = bus.lu_wb_valid && lu_ready && !direct;
    assign count_next = count + CW'(enq) - CW'(deq);

    // Clear the bit of a long-unit result reaching the port, then apply a
    // new issue so that set wins when both name the same register.
    always_comb begin
        sb_next = sb;
        if ((deq || direct) && port_rd != 5'd0) sb_next[port_rd] = 1'b0;
        if (bus.lu_issue_valid && bus.lu_issue_rd != 5'd0) sb_next[bus.lu_issue_rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    assign bus.wb_regwen    = port_valid && (port_rd != 5'd0);
    assign bus.wb_rd        = port_rd;
    assign bus.wb_data      = port_data;
    assign bus.lu_wb_ready  = lu_ready;
    assign bus.stall_pipe   = (state == S_FORCE);
    assign bus.dbg_state    = state;
    assign bus.stall_decode =
        (bus.dec_rs1_used && bus.dec_rs1 != 5'd0 && sb[bus.dec_rs1]) |
        (bus.dec_rs2_used && bus.dec_rs2 != 5'd0 && sb[bus.dec_rs2]) |
        (bus.dec_regwen   && bus.dec_rd  != 5'd0 && sb[bus.dec_rd]);

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            fifo_rd[wr_ptr]   <= bus.lu_wb_rd;
            fifo_data[wr_ptr] <= bus.lu_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            sb       <= '0;
        end else begin
            count <= count_next;
            sb    <= sb_next;
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case (state)
                S_IDLE: begin
                    if (enq) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (deq) begin
                        wait_cnt <= '0;
                        if (count_next == '0) state <= S_IDLE;
                    end else if (wait_cnt == WW'(STARVE_LIMIT - 1)) begin
                        // wait_cnt is cleared by the forced write itself
                        state <= S_FORCE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_FORCE: begin
                    wait_cnt <= '0;
                    state    <= (count_next == '0) ? S_IDLE : S_DRAIN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_conf_q;
    logic [31:0] perf_force_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conf_q  <= '0;
            perf_force_q <= '0;
        end else begin
            if (bus.pipe_wb_valid && (!fifo_empty || bus.lu_wb_valid))
                perf_conf_q <= perf_conf_q + 32'd1;
            if (state == S_FORCE)
                perf_force_q <= perf_force_q + 32'd1;
        end
    end

    assign bus.perf_conflicts = perf_conf_q;
    assign bus.perf_forced    = perf_force_q;
`else
    assign bus.perf_conflicts = '0;
    assign bus.perf_forced    = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed scenarios followed by a randomized run. Every cycle the port,
//   ready and stall outputs are compared with a reference model that keeps
//   buffered results in a queue, the scoreboard as a 32-bit set, and the
//   starvation rule as a running count of denied cycles.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic clk;
    logic rst;
    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [36:0] mq[$];
    logic [31:0] msb;
    int          mdenied;
    bit          mforce;
    logic [31:0] mperf_c;
    logic [31:0] mperf_f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        msb     = '0;
        mdenied = 0;
        mforce  = 1'b0;
        mperf_c = '0;
        mperf_f = '0;
    endtask

    task automatic idle_inputs();
        bus.pipe_wb_valid  = 1'b0;
        bus.pipe_wb_rd     = '0;
        bus.pipe_wb_data   = '0;
        bus.lu_issue_valid = 1'b0;
        bus.lu_issue_rd    = '0;
        bus.lu_wb_valid    = 1'b0;
        bus.lu_wb_rd       = '0;
        bus.lu_wb_data     = '0;
        bus.dec_rs1        = '0;
        bus.dec_rs2        = '0;
        bus.dec_rd         = '0;
        bus.dec_rs1_used   = 1'b0;
        bus.dec_rs2_used   = 1'b0;
        bus.dec_regwen     = 1'b0;
    endtask

    // One clock: compare outputs against the model for the current inputs,
    // then advance the model across the rising edge.
    task automatic tick();
        bit          src_pipe, src_head, src_direct, have, enq, ready, sdec;
        bit          conflict, was_force, was_busy;
        logic [36:0] head;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] nsb;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        #1;
        head  = (mq.size() > 0) ? mq[0] : 37'd0;
        ready = (mq.size() < DEPTH);
        src_pipe = 0; src_head = 0; src_direct = 0;
        if (mforce)                   src_head   = 1;
        else if (bus.pipe_wb_valid)   src_pipe   = 1;
        else if (mq.size() > 0)       src_head   = 1;
        else if (bus.lu_wb_valid)     src_direct = 1;
        e_rd = '0; e_data = '0;
        if (src_pipe)        begin e_rd = bus.pipe_wb_rd; e_data = bus.pipe_wb_data; end
        else if (src_head)   begin e_rd = head[36:32];    e_data = head[31:0];       end
        else if (src_direct) begin e_rd = bus.lu_wb_rd;   e_data = bus.lu_wb_data;   end
        have = src_pipe || src_head || src_direct;
        enq  = bus.lu_wb_valid && ready && !src_direct;
        sdec = (bus.dec_rs1_used && bus.dec_rs1 != 0 && msb[bus.dec_rs1]) ||
               (bus.dec_rs2_used && bus.dec_rs2 != 0 && msb[bus.dec_rs2]) ||
               (bus.dec_regwen   && bus.dec_rd  != 0 && msb[bus.dec_rd]);
        if (!rst) begin
            chk("wb_regwen",    32'(bus.wb_regwen),    32'(have && e_rd != 0));
            chk("wb_rd",        32'(bus.wb_rd),        32'(e_rd));
            chk("wb_data",      bus.wb_data,           e_data);
            chk("lu_wb_ready",  32'(bus.lu_wb_ready),  32'(ready));
            chk("stall_pipe",   32'(bus.stall_pipe),   32'(mforce));
            chk("stall_decode", 32'(bus.stall_decode), 32'(sdec));
`ifdef WB_ARB_PERF_EN
            chk("perf_conflicts", bus.perf_conflicts, mperf_c);
            chk("perf_forced",    bus.perf_forced,    mperf_f);
`else
            chk("perf_conflicts", bus.perf_conflicts, 32'd0);
            chk("perf_forced",    bus.perf_forced,    32'd0);
`endif
        end
        nsb = msb;
        if ((src_head || src_direct) && e_rd != 0) nsb[e_rd] = 1'b0;
        if (bus.lu_issue_valid && bus.lu_issue_rd != 0) nsb[bus.lu_issue_rd] = 1'b1;
        conflict  = bus.pipe_wb_valid && (mq.size() > 0 || bus.lu_wb_valid);
        was_force = mforce;
        was_busy  = (mq.size() > 0);
        lrd   = bus.lu_wb_rd;
        ldata = bus.lu_wb_data;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            msb = nsb;
            if (src_head) void'(mq.pop_front());
            if (enq) mq.push_back({lrd, ldata});
            if (conflict)  mperf_c = mperf_c + 1;
            if (was_force) mperf_f = mperf_f + 1;
            if (was_force) begin
                mforce  = 0;
                mdenied = 0;
            end else if (was_busy && !src_head) begin
                if (mdenied == LIMIT - 1) mforce = 1;
                else mdenied++;
            end else begin
                mdenied = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int force_cycles;
        int first_force;
        model_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        #1;
        chk("rst_wb_regwen",    32'(bus.wb_regwen),    32'd0);
        chk("rst_wb_rd",        32'(bus.wb_rd),        32'd0);
        chk("rst_wb_data",      bus.wb_data,           32'd0);
        chk("rst_stall_decode", 32'(bus.stall_decode), 32'd0);
        chk("rst_stall_pipe",   32'(bus.stall_pipe),   32'd0);
        chk("rst_lu_wb_ready",  32'(bus.lu_wb_ready),  32'd1);
        chk("rst_perf_conf",    bus.perf_conflicts,    32'd0);
        chk("rst_perf_forced",  bus.perf_forced,       32'd0);
        tick();

        // RAW hazard on x5, then direct pass-through clears it
        bus.lu_issue_valid = 1'b1;
        bus.lu_issue_rd    = 5'd5;
        tick();
        idle_inputs();
        bus.dec_rs1      = 5'd5;
        bus.dec_rs1_used = 1'b1;
        #1;
        chk("raw_stall_set", 32'(bus.stall_decode), 32'd1);
        tick();
        bus.lu_wb_valid = 1'b1;
        bus.lu_wb_rd    = 5'd5;
        bus.lu_wb_data  = 32'hDEAD;
        #1;
        chk("direct_regwen", 32'(bus.wb_regwen), 32'd1);
        chk("direct_rd",     32'(bus.wb_rd),     32'd5);
        chk("direct_data",   bus.wb_data,        32'hDEAD);
        tick();
        bus.lu_wb_valid = 1'b0;
        #1;
        chk("raw_stall_clr", 32'(bus.stall_decode), 32'd0);
        tick();
        idle_inputs();

        // Starvation: pipeline writes every cycle while x7's result waits
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = 5'd1;
        bus.pipe_wb_data  = $urandom;
        bus.lu_wb_valid   = 1'b1;
        bus.lu_wb_rd      = 5'd7;
        bus.lu_wb_data    = 32'hBEEF;
        tick();
        bus.lu_wb_valid = 1'b0;
        force_cycles = 0;
        first_force  = -1;
        for (int i = 0; i < 20; i++) begin
            bus.pipe_wb_data = $urandom;
            #1;
            if (bus.stall_pipe) begin
                force_cycles++;
                if (first_force < 0) first_force = i;
                chk("force_rd", 32'(bus.wb_rd), 32'd7);
            end
            tick();
        end
        chk("force_count", 32'(force_cycles), 32'd1);
        chk("force_when",  32'(first_force),  32'(LIMIT));
        idle_inputs();
        tick();

        // Fill the FIFO behind a busy pipeline, then drain in order
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = 5'd2;
        for (int k = 0; k < 5; k++) begin
            bus.lu_wb_valid = 1'b1;
            bus.lu_wb_rd    = 5'(10 + k);
            bus.lu_wb_data  = 32'(k);
            #1;
            chk("fill_ready", 32'(bus.lu_wb_ready), 32'(k < DEPTH));
            tick();
        end
        bus.lu_wb_valid   = 1'b0;
        bus.pipe_wb_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            chk("drain_rd",     32'(bus.wb_rd),     32'(10 + k));
            chk("drain_regwen", 32'(bus.wb_regwen), 32'd1);
            tick();
        end
        #1;
        chk("drain_empty", 32'(bus.wb_regwen), 32'd0);
        tick();

        // x0 result: accepted, never written, never buffered
        bus.lu_wb_valid = 1'b1;
        bus.lu_wb_rd    = 5'd0;
        bus.lu_wb_data  = 32'h1234;
        #1;
        chk("x0_regwen", 32'(bus.wb_regwen),   32'd0);
        chk("x0_ready",  32'(bus.lu_wb_ready), 32'd1);
        tick();
        bus.lu_wb_valid = 1'b0;
        #1;
        chk("x0_not_buffered", 32'(bus.wb_regwen), 32'd0);
        tick();

        // Reset while results are buffered and x9 is pending
        bus.pipe_wb_valid  = 1'b1;
        bus.pipe_wb_rd     = 5'd3;
        bus.lu_issue_valid = 1'b1;
        bus.lu_issue_rd    = 5'd9;
        for (int k = 0; k < 3; k++) begin
            bus.lu_wb_valid = 1'b1;
            bus.lu_wb_rd    = 5'(20 + k);
            bus.lu_wb_data  = $urandom;
            tick();
            bus.lu_issue_valid = 1'b0;
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dec_rs1      = 5'd9;
        bus.dec_rs1_used = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(bus.stall_decode), 32'd0);
        chk("mid_rst_ready", 32'(bus.lu_wb_ready),  32'd1);
        chk("mid_rst_empty", 32'(bus.wb_regwen),    32'd0);
        chk("mid_rst_perf",  bus.perf_conflicts,    32'd0);
        tick();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst                = ($urandom_range(0, 299) == 0);
            bus.pipe_wb_valid  = ($urandom_range(0, 9) < 7);
            bus.pipe_wb_rd     = 5'($urandom_range(0, 31));
            bus.pipe_wb_data   = $urandom;
            bus.lu_issue_valid = ($urandom_range(0, 9) < 3);
            bus.lu_issue_rd    = 5'($urandom_range(0, 7));
            bus.lu_wb_valid    = ($urandom_range(0, 9) < 4);
            bus.lu_wb_rd       = 5'($urandom_range(0, 7));
            bus.lu_wb_data     = $urandom;
            bus.dec_rs1        = 5'($urandom_range(0, 7));
            bus.dec_rs2        = 5'($urandom_range(0, 7));
            bus.dec_rd         = 5'($urandom_range(0, 7));
            bus.dec_rs1_used   = 1'($urandom_range(0, 1));
            bus.dec_rs2_used   = 1'($urandom_range(0, 1));
            bus.dec_regwen     = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
